// File: rtl/branch_pkg.sv
// Shared constants for the branch unit: condition codes, 2-bit BHT counter
// states, flag bit positions and the counter training helper.
package branch_pkg;

    // Condition codes carried by a branch instruction
    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_OV     = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    // Bimodal counter states; the MSB is the predicted direction
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Bit positions inside the {Z,V,N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Saturating step of a 2-bit counter towards the resolved direction
    function automatic logic [1:0] bht_next(input logic [1:0] state, input logic taken);
        logic [1:0] result;
        if (taken) begin
            result = (state == ST) ? ST : state + 2'd1;
        end else begin
            result = (state == SNT) ? SNT : state - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Pure combinational evaluation of a 3-bit branch condition against Z/V/N.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       v,
    input  logic       n,
    output logic       taken
);

    // Decode the condition code into a taken/not-taken decision
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE:     taken = ~z;
            COND_EQ:     taken = z;
            COND_GT:     taken = ~z & ~n;
            COND_LT:     taken = n;
            COND_GE:     taken = z | ~n;
            COND_LE:     taken = z | n;
            COND_OV:     taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: Z/V/N flag register, condition evaluation with same-cycle
// flag bypass, bimodal 2-bit BHT prediction at fetch, registered resolution
// at execute and a saturating mispredict counter.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int PC_W       = 16,
    parameter int BHT_DEPTH  = 16,
    parameter int CNT_W      = 16,
    parameter bit PREDICT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  logic [2:0]       flag_mask,
    input  logic [2:0]       flag_in,
    output logic [2:0]       flags,
    input  logic [PC_W-1:0]  pc_f,
    output logic             pred_taken,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic [PC_W-1:0]  br_pc,
    input  logic             br_pred,
    input  logic             flush,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [2:0]       flags_q;
    logic [2:0]       flags_merged;
    logic [2:0]       flags_eff;
    logic             cond_taken;
    logic             br_accept;
    logic             pred_ref;
    logic             mispredict_now;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    logic [1:0]       bht [BHT_DEPTH];
    logic             unused_pc_bits;

    // Halfword-aligned PCs: bit 0 and the bits above the index never matter
    assign unused_pc_bits = ^{pc_f[0], pc_f[PC_W-1:IDX_W+1], br_pc[0], br_pc[PC_W-1:IDX_W+1]};

    assign flags_merged   = (flags_q & ~flag_mask) | (flag_in & flag_mask);
    assign flags_eff      = flag_we ? flags_merged : flags_q;
    assign flags          = flags_q;
    assign lookup_idx     = pc_f[IDX_W:1];
    assign update_idx     = br_pc[IDX_W:1];
    assign br_accept      = br_valid & ~flush;
    assign pred_ref       = PREDICT_EN ? br_pred : 1'b0;
    assign mispredict_now = cond_taken ^ pred_ref;

    branch_cond_eval u_cond_eval (
        .cond  (br_cond),
        .z     (flags_eff[FLAG_Z]),
        .v     (flags_eff[FLAG_V]),
        .n     (flags_eff[FLAG_N]),
        .taken (cond_taken)
    );

    // Flag register: masked write of the ALU result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else if (flag_we) begin
            flags_q <= flags_merged;
        end
    end

    // BHT training with the resolved direction of each surviving branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= WNT;
            end
        end else if (br_accept && PREDICT_EN) begin
            bht[update_idx] <= bht_next(bht[update_idx], cond_taken);
        end
    end

    // Zero-cycle fetch lookup; sees the table before any same-edge update
    always_comb begin
        pred_taken = 1'b0;
        if (PREDICT_EN) begin
            pred_taken = bht[lookup_idx][1];
        end
    end

    // Registered resolution result; a flushed or absent branch yields no result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_mispredict <= 1'b0;
        end else begin
            res_valid      <= br_accept;
            res_taken      <= br_accept & cond_taken;
            res_mispredict <= br_accept & mispredict_now;
        end
    end

    // Saturating mispredict counter, sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt <= '0;
        end else if (br_accept && mispredict_now && (mispred_cnt != {CNT_W{1'b1}})) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit: reset, condition table, flag
// bypass, BHT training, mispredict/flush and counter saturation.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic        flag_we;
    logic [2:0]  flag_mask;
    logic [2:0]  flag_in;
    logic [15:0] pc_f;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic        br_pred;
    logic        flush;

    logic [2:0]  flags;
    logic        pred_taken;
    logic        res_valid;
    logic        res_taken;
    logic        res_mispredict;
    logic [15:0] mispred_cnt;

    logic [2:0]  flags_sat;
    logic        pred_taken_sat;
    logic        res_valid_sat;
    logic        res_taken_sat;
    logic        res_mispredict_sat;
    logic [3:0]  mispred_cnt_sat;

    int checks;
    int errors;

    logic [7:0] goldenTable [8];

    branch_predict_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flag_we        (flag_we),
        .flag_mask      (flag_mask),
        .flag_in        (flag_in),
        .flags          (flags),
        .pc_f           (pc_f),
        .pred_taken     (pred_taken),
        .br_valid       (br_valid),
        .br_cond        (br_cond),
        .br_pc          (br_pc),
        .br_pred        (br_pred),
        .flush          (flush),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .mispred_cnt    (mispred_cnt)
    );

    branch_predict_unit #(.CNT_W(4)) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .flag_we        (flag_we),
        .flag_mask      (flag_mask),
        .flag_in        (flag_in),
        .flags          (flags_sat),
        .pc_f           (pc_f),
        .pred_taken     (pred_taken_sat),
        .br_valid       (br_valid),
        .br_cond        (br_cond),
        .br_pc          (br_pc),
        .br_pred        (br_pred),
        .flush          (flush),
        .res_valid      (res_valid_sat),
        .res_taken      (res_taken_sat),
        .res_mispredict (res_mispredict_sat),
        .mispred_cnt    (mispred_cnt_sat)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it when it does not match
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One branch in execute for one cycle; result is registered on return
    task automatic applyStimulus(input logic [2:0] cond, input logic [15:0] pc,
                                 input logic pred, input logic fl);
        br_valid = 1'b1;
        br_cond  = cond;
        br_pc    = pc;
        br_pred  = pred;
        flush    = fl;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Registered flag write with no branch alongside
    task automatic setFlags(input logic [2:0] mask, input logic [2:0] val);
        flag_we   = 1'b1;
        flag_mask = mask;
        flag_in   = val;
        @(posedge clk);
        #1;
        flag_we = 1'b0;
    endtask

    // Prediction for a given fetch PC, sampled between edges
    task automatic checkPred(input string tag, input logic [15:0] pc, input logic expected);
        pc_f = pc;
        #1;
        checkOutput(tag, {31'd0, pred_taken}, {31'd0, expected});
    endtask

    // Directed test sequence
    initial begin
        logic tv;

        checks = 0;
        errors = 0;

        // Taken pattern per condition code, bit index = {Z,V,N}
        goldenTable[0] = 8'h0F;
        goldenTable[1] = 8'hF0;
        goldenTable[2] = 8'h05;
        goldenTable[3] = 8'hAA;
        goldenTable[4] = 8'hF5;
        goldenTable[5] = 8'hFA;
        goldenTable[6] = 8'hCC;
        goldenTable[7] = 8'hFF;

        rst_n     = 1'b0;
        flag_we   = 1'b0;
        flag_mask = 3'b000;
        flag_in   = 3'b000;
        pc_f      = 16'h0000;
        br_valid  = 1'b0;
        br_cond   = 3'b000;
        br_pc     = 16'h0000;
        br_pred   = 1'b0;
        flush     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_flags", {29'd0, flags}, 32'd0);
        checkOutput("reset_cnt", {16'd0, mispred_cnt}, 32'd0);
        checkOutput("reset_res_valid", {31'd0, res_valid}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            checkPred($sformatf("reset_pred_idx%0d", i), 16'(i << 1), 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                setFlags(3'b111, 3'(f));
                if (c == 0) begin
                    checkOutput($sformatf("flags_write_%0d", f), {29'd0, flags}, 32'(f));
                end
                tv = goldenTable[c][f];
                applyStimulus(3'(c), 16'h0040, tv, 1'b0);
                checkOutput($sformatf("cond%0d_zvn%0d", c, f), {31'd0, res_taken}, {31'd0, tv});
            end
        end
        checkOutput("cond_res_valid", {31'd0, res_valid}, 32'd1);
        checkOutput("cond_no_mispredict_cnt", {16'd0, mispred_cnt}, 32'd0);

        setFlags(3'b111, 3'b000);
        setFlags(3'b100, 3'b111);
        checkOutput("flag_mask_hold", {29'd0, flags}, 32'h4);
        setFlags(3'b111, 3'b000);

        flag_we   = 1'b1;
        flag_mask = 3'b100;
        flag_in   = 3'b100;
        applyStimulus(3'b001, 16'h0040, 1'b1, 1'b0);
        flag_we = 1'b0;
        checkOutput("bypass_taken", {31'd0, res_taken}, 32'd1);
        checkOutput("bypass_flags", {29'd0, flags}, 32'h4);

        setFlags(3'b111, 3'b000);
        flag_we   = 1'b1;
        flag_mask = 3'b000;
        flag_in   = 3'b100;
        applyStimulus(3'b001, 16'h0040, 1'b0, 1'b0);
        flag_we = 1'b0;
        checkOutput("nobypass_taken", {31'd0, res_taken}, 32'd0);
        checkOutput("nobypass_flags", {29'd0, flags}, 32'd0);

        @(posedge clk);
        #1;
        checkOutput("idle_res_valid", {31'd0, res_valid}, 32'd0);

        checkPred("train_pred_initial", 16'h0004, 1'b0);
        br_valid = 1'b1;
        br_cond  = 3'b111;
        br_pc    = 16'h0004;
        br_pred  = 1'b0;
        #1;
        checkOutput("same_cycle_pre_update", {31'd0, pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        checkOutput("train1_mispredict", {31'd0, res_mispredict}, 32'd1);
        checkOutput("train1_cnt", {16'd0, mispred_cnt}, 32'd1);
        checkOutput("train1_pred", {31'd0, pred_taken}, 32'd1);
        checkPred("train1_alias_pred", 16'h0024, 1'b1);

        applyStimulus(3'b111, 16'h0004, 1'b1, 1'b0);
        checkOutput("train2_mispredict", {31'd0, res_mispredict}, 32'd0);
        checkPred("train2_pred", 16'h0004, 1'b1);
        applyStimulus(3'b111, 16'h0004, 1'b1, 1'b0);
        checkPred("train3_pred_sat", 16'h0004, 1'b1);

        applyStimulus(3'b001, 16'h0004, 1'b1, 1'b0);
        checkOutput("nt1_taken", {31'd0, res_taken}, 32'd0);
        checkOutput("nt1_mispredict", {31'd0, res_mispredict}, 32'd1);
        checkOutput("nt1_cnt", {16'd0, mispred_cnt}, 32'd2);
        checkPred("nt1_pred", 16'h0004, 1'b1);
        applyStimulus(3'b001, 16'h0004, 1'b0, 1'b0);
        checkPred("nt2_pred", 16'h0004, 1'b0);
        checkPred("nt2_alias_pred", 16'h0024, 1'b0);

        applyStimulus(3'b111, 16'h0008, 1'b0, 1'b1);
        checkOutput("flush_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("flush_cnt", {16'd0, mispred_cnt}, 32'd2);
        checkPred("flush_bht_unchanged", 16'h0008, 1'b0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(3'b111, 16'h000A, 1'b0, 1'b0);
        end
        checkOutput("sat_cnt_wide", {16'd0, mispred_cnt}, 32'd22);
        checkOutput("sat_cnt_narrow", {28'd0, mispred_cnt_sat}, 32'hF);
        checkPred("sat_pred_trained", 16'h000A, 1'b1);

        setFlags(3'b111, 3'b111);
        applyStimulus(3'b111, 16'h000A, 1'b1, 1'b0);
        checkOutput("pre_reset_res_valid", {31'd0, res_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_flags", {29'd0, flags}, 32'd0);
        checkOutput("midreset_cnt", {16'd0, mispred_cnt}, 32'd0);
        checkOutput("midreset_cnt_narrow", {28'd0, mispred_cnt_sat}, 32'd0);
        checkOutput("midreset_res_valid", {31'd0, res_valid}, 32'd0);
        checkPred("midreset_pred", 16'h000A, 1'b0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
